magnitude_comparator: RTL and testbench



---
 rtl/cmp_pkg.sv | 24 ++
 rtl/magnitude_cmp_slice.sv | 17 +
 rtl/magnitude_comparator.sv | 91 +++++++++
 tb/tb_magnitude_comparator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the magnitude comparator.
//   cmp_res_t     : local compare result of a bit range (gt, eq)
//   cmp_merge()   : combines a more-significant and a less-significant result
//   CMP_RES_IDENT : neutral element of cmp_merge when used as the low half
//   CMP_FLAGS_RST : reset value of the registered {x, y, z} flags
package cmp_pkg;

  typedef struct packed {
    logic gt;
    logic eq;
  } cmp_res_t;

  localparam cmp_res_t   CMP_RES_IDENT = '{gt: 1'b0, eq: 1'b1};
  localparam logic [2:0] CMP_FLAGS_RST = '0;

  // The high half decides unless it is equal, in which case the low half does.
  function automatic cmp_res_t cmp_merge(input cmp_res_t hi, input cmp_res_t lo);
    cmp_res_t r;
    r.gt = hi.gt | (hi.eq & lo.gt);
    r.eq = hi.eq & lo.eq;
    return r;
  endfunction

endpackage

// File: rtl/magnitude_cmp_slice.sv
// One-bit comparator slice. Purely combinational.
//   i_a, i_b : one bit of each operand
//   o_res    : local result (gt = a>b, eq = a==b) for this bit
module magnitude_cmp_slice
  import cmp_pkg::*;
(
  input  logic     i_a,
  input  logic     i_b,
  output cmp_res_t o_res
);

  always_comb begin
    o_res.gt = i_a & ~i_b;
    o_res.eq = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/magnitude_comparator.sv
// Registered magnitude comparator: one result per qualified input, 1-cycle latency.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : qualifies a and b this cycle
//   a, b        : WIDTH-bit operands (two's complement when SIGNED=1)
//   x, y, z     : registered one-hot flags a>b, a==b, a<b (held while idle)
//   out_valid   : registered copy of in_valid
module magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter logic        SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             out_valid
);

  // Leaf count rounded up to a power of two so the tree is a full binary tree.
  localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int unsigned P      = 1 << LEVELS;

  logic [WIDTH-1:0] w_a_adj;
  logic [WIDTH-1:0] w_b_adj;
  logic             w_gt;
  logic             w_eq;
  logic             r_x;
  logic             r_y;
  logic             r_z;
  logic             r_valid;

  // Flipping both sign bits maps two's complement order onto unsigned order.
  always_comb begin
    w_a_adj            = a;
    w_b_adj            = b;
    w_a_adj[WIDTH-1]   = a[WIDTH-1] ^ SIGNED;
    w_b_adj[WIDTH-1]   = b[WIDTH-1] ^ SIGNED;
  end

  // Heap-ordered tree: node 1 is the root, node k has children 2k (more
  // significant) and 2k+1 (less significant). Leaf P+i holds bit WIDTH-1-i,
  // so padding leaves sit below the LSB and merge as the identity.
  cmp_res_t w_node [1:2*P-1];

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      if (gi < WIDTH) begin : g_bit
        magnitude_cmp_slice u_slice (
          .i_a   (w_a_adj[WIDTH-1-gi]),
          .i_b   (w_b_adj[WIDTH-1-gi]),
          .o_res (w_node[P+gi])
        );
      end else begin : g_pad
        assign w_node[P+gi] = CMP_RES_IDENT;
      end
    end

    for (gi = 1; gi < P; gi++) begin : g_merge
      assign w_node[gi] = cmp_merge(w_node[2*gi], w_node[2*gi+1]);
    end
  endgenerate

  assign w_gt = w_node[1].gt;
  assign w_eq = w_node[1].eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_x, r_y, r_z} <= CMP_FLAGS_RST;
      r_valid         <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_x <= w_gt;
        r_y <= w_eq;
        r_z <= ~w_gt & ~w_eq;
      end
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign z         = r_z;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Self-checking bench for magnitude_comparator across five configurations.
module tb_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] v;
  logic       a1, b1;
  logic [7:0] a8u, b8u, a8s, b8s;
  logic [3:0] a4u, b4u, a4s, b4s;
  logic [2:0] f [5];
  logic [4:0] ov;

  logic [2:0] q [5][$];
  int         pulses [5];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  magnitude_comparator #(.WIDTH(1), .SIGNED(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .a(a1), .b(b1),
    .x(f[0][2]), .y(f[0][1]), .z(f[0][0]), .out_valid(ov[0]));
  magnitude_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (
    .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .a(a8u), .b(b8u),
    .x(f[1][2]), .y(f[1][1]), .z(f[1][0]), .out_valid(ov[1]));
  magnitude_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (
    .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .a(a8s), .b(b8s),
    .x(f[2][2]), .y(f[2][1]), .z(f[2][0]), .out_valid(ov[2]));
  magnitude_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_w4u (
    .clk(clk), .rst_n(rst_n), .in_valid(v[3]), .a(a4u), .b(b4u),
    .x(f[3][2]), .y(f[3][1]), .z(f[3][0]), .out_valid(ov[3]));
  magnitude_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_w4s (
    .clk(clk), .rst_n(rst_n), .in_valid(v[4]), .a(a4s), .b(b4s),
    .x(f[4][2]), .y(f[4][1]), .z(f[4][0]), .out_valid(ov[4]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_u(input longint unsigned ra, input longint unsigned rb);
    return {ra > rb, ra == rb, ra < rb};
  endfunction

  function automatic logic [2:0] ref_s(input longint ra, input longint rb);
    return {ra > rb, ra == rb, ra < rb};
  endfunction

  task automatic mon(input int k, input string tag);
    logic [2:0] e;
    if (ov[k]) begin
      pulses[k]++;
      if (q[k].size() == 0) begin
        check({tag, "_unexpected_valid"}, 1, 0);
      end else begin
        e = q[k].pop_front();
        check({tag, "_flags"}, f[k], e);
        check({tag, "_onehot"}, $countones(f[k]), 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, "w1");
      mon(1, "w8u");
      mon(2, "w8s");
      mon(3, "w4u");
      mon(4, "w4s");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    v = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_flags%0d", tag, k), f[k], 3'b000);
      check($sformatf("%s_valid%0d", tag, k), ov[k], 1'b0);
    end
  endtask

  logic [2:0] w1_exp [4] = '{3'b010, 3'b001, 3'b100, 3'b010};
  logic [7:0] u8_a [4]   = '{8'h80, 8'h00, 8'hA5, 8'h3C};
  logic [7:0] u8_b [4]   = '{8'h7F, 8'hFF, 8'hA5, 8'hC3};
  logic [2:0] u8_e [4]   = '{3'b100, 3'b001, 3'b010, 3'b001};
  logic [7:0] s8_a [4]   = '{8'h80, 8'hFF, 8'h01, 8'h7F};
  logic [7:0] s8_b [4]   = '{8'h7F, 8'h00, 8'hFF, 8'h80};
  logic [2:0] s8_e [4]   = '{3'b001, 3'b001, 3'b100, 3'b100};

  initial begin
    int p0;
    v = '0;
    a1 = 0; b1 = 0; a8u = 0; b8u = 0; a8s = 0; b8s = 0;
    a4u = 0; b4u = 0; a4s = 0; b4s = 0;
    for (int k = 0; k < 5; k++) pulses[k] = 0;
    rst_n = 1'b0;
    #2;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check_all_zero("idle_after_rst");

    // WIDTH=1 truth table, one qualified cycle every 100 ns
    for (int i = 0; i < 4; i++) begin
      step();
      v[0] = 1'b1;
      a1 = i[1];
      b1 = i[0];
      q[0].push_back(w1_exp[i]);
      repeat (9) step();
    end

    // Async reset while x=1, with another compare in flight
    step();
    v[0] = 1'b1; a1 = 1'b1; b1 = 1'b0;
    q[0].push_back(3'b100);
    step();
    check("w1_x_before_rst", f[0][2], 1'b1);
    v[0] = 1'b1; a1 = 1'b1; b1 = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    v = '0;
    for (int k = 0; k < 5; k++) q[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all_zero("after_midrst");

    // 8-bit directed vectors, back-to-back, then hold
    p0 = pulses[1];
    for (int i = 0; i < 4; i++) begin
      step();
      v[1] = 1'b1; v[2] = 1'b1;
      a8u = u8_a[i]; b8u = u8_b[i];
      a8s = s8_a[i]; b8s = s8_b[i];
      q[1].push_back(u8_e[i]);
      q[2].push_back(s8_e[i]);
    end
    step();
    @(negedge clk);
    #1;
    check("w8u_pulses", pulses[1] - p0, 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check("hold_valid", ov[1], 1'b0);
      check("hold_flags", f[1], u8_e[3]);
      check("hold_flags_s", f[2], s8_e[3]);
    end

    // 8-bit random, with idle gaps
    for (int i = 0; i < 40; i++) begin
      step();
      if ($urandom_range(3) != 0) begin
        v[1] = 1'b1;
        a8u = 8'($urandom);
        b8u = (i % 5 == 0) ? a8u : 8'($urandom);
        q[1].push_back(ref_u(a8u, b8u));
      end
      if ($urandom_range(3) != 0) begin
        v[2] = 1'b1;
        a8s = 8'($urandom);
        b8s = (i % 7 == 0) ? a8s : 8'($urandom);
        q[2].push_back(ref_s(longint'($signed(a8s)), longint'($signed(b8s))));
      end
    end

    // Exhaustive 4-bit, unsigned and signed
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        step();
        v[3] = 1'b1; v[4] = 1'b1;
        a4u = 4'(ia); b4u = 4'(ib);
        a4s = 4'(ia); b4s = 4'(ib);
        q[3].push_back(ref_u(a4u, b4u));
        q[4].push_back(ref_s(longint'($signed(a4s)), longint'($signed(b4s))));
      end
    end

    repeat (4) step();
    for (int k = 0; k < 5; k++)
      check($sformatf("drained%0d", k), q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
